// File: rtl/ccb_pkg.sv
// Shared definitions for the CCB command-decoder downstream stages:
// sync FSM encoding, LHC orbit constants and the BX wrap helper.
package ccb_pkg;

   localparam int BXN_W      = 12;
   localparam int LHC_BX_MAX = 3563;

   localparam logic [BXN_W-1:0] BX_ONE = BXN_W'(1);

   typedef enum logic [1:0] {
      ST_UNSYNC = 2'd0,
      ST_SYNCED = 2'd1,
      ST_ERROR  = 2'd2
   } sync_state_e;

   // Orbit-wrapped increment: the last BX of the orbit is followed by the offset.
   function automatic logic [BXN_W-1:0] bx_wrap_inc(
      input logic [BXN_W-1:0] bx,
      input logic [BXN_W-1:0] max_v,
      input logic [BXN_W-1:0] off_v
   );
      return (bx == max_v) ? off_v : bx + BX_ONE;
   endfunction

endpackage

// File: rtl/bx_orbit_cntr.sv
// Orbit-aligned bunch-crossing counter. Exposes the natural next value
// (what the counter would become without a reload) for BC0 alignment checks.
module bx_orbit_cntr
   import ccb_pkg::*;
#(
   parameter int BX_MAX    = LHC_BX_MAX,
   parameter int BX_OFFSET = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clkena,
   input  logic             load,
   output logic [BXN_W-1:0] bxn,
   output logic [BXN_W-1:0] bxn_next
);

   localparam logic [BXN_W-1:0] MAX_V = BXN_W'(BX_MAX);
   localparam logic [BXN_W-1:0] OFF_V = BXN_W'(BX_OFFSET);

   assign bxn_next = clkena ? bx_wrap_inc(bxn, MAX_V, OFF_V) : bxn;

   // Reload wins over counting and is independent of clkena.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bxn <= '0;
      end else if (load) begin
         bxn <= OFF_V;
      end else begin
         bxn <= bxn_next;
      end
   end

endmodule

// File: rtl/bxl1a_cntr.sv
// BX / L1A event counter stage with BC0 alignment FSM and 1-cycle L1A tagging.
// Build option: define BXL1A_ERRCNT_EN to include the saturating BC0 mismatch counter.
module bxl1a_cntr
   import ccb_pkg::*;
#(
   parameter int BX_MAX    = LHC_BX_MAX,
   parameter int BX_OFFSET = 0,
   parameter int L1A_WIDTH = 24
) (
   input  logic                 CLKCMS,
   input  logic                 RSTN,
   input  logic                 CLKENA,
   input  logic                 BC0,
   input  logic                 BXRST,
   input  logic                 L1ARST,
   input  logic                 L1ASRST,
   input  logic                 L1A,
   output logic [BXN_W-1:0]     BXN,
   output logic [L1A_WIDTH-1:0] L1ACNT,
   output logic                 L1A_VALID,
   output logic [BXN_W-1:0]     L1A_BXN,
   output logic [L1A_WIDTH-1:0] L1A_NUM,
   output logic                 SYNCED,
   output logic                 BC0_ERR,
   output logic [7:0]           BC0_ERRCNT,
   output logic [1:0]           fsm_state
);

   localparam logic [BXN_W-1:0]     OFF_V   = BXN_W'(BX_OFFSET);
   localparam logic [L1A_WIDTH-1:0] CNT_ONE = L1A_WIDTH'(1);

   sync_state_e          state, state_nxt;
   logic                 err_nxt;
   logic [BXN_W-1:0]     bxn_next;
   logic                 bc0_mismatch;
   logic                 l1a_acc;
   logic [L1A_WIDTH-1:0] cnt_new;

   bx_orbit_cntr #(
      .BX_MAX    (BX_MAX),
      .BX_OFFSET (BX_OFFSET)
   ) u_bx (
      .clk      (CLKCMS),
      .rst_n    (RSTN),
      .clkena   (CLKENA),
      .load     (BC0 | BXRST),
      .bxn      (BXN),
      .bxn_next (bxn_next)
   );

   // BXRST coinciding with BC0 suppresses the alignment check.
   assign bc0_mismatch = BC0 && !BXRST && (bxn_next != OFF_V);

   always_ff @(posedge CLKCMS or negedge RSTN) begin
      if (!RSTN) begin
         state   <= ST_UNSYNC;
         BC0_ERR <= 1'b0;
      end else begin
         state   <= state_nxt;
         BC0_ERR <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      err_nxt   = BC0_ERR;
      case (state)
         ST_UNSYNC: begin
            if (BC0 || BXRST) state_nxt = ST_SYNCED;
         end
         ST_SYNCED: begin
            if (bc0_mismatch) begin
               state_nxt = ST_ERROR;
               err_nxt   = 1'b1;
            end
         end
         ST_ERROR: begin
            if (BXRST) begin
               state_nxt = ST_SYNCED;
               err_nxt   = 1'b0;
            end
         end
         default: begin
            state_nxt = ST_UNSYNC;
            err_nxt   = 1'b0;
         end
      endcase
   end

   assign SYNCED    = (state != ST_UNSYNC);
   assign fsm_state = state;

   // An L1A coinciding with L1ARST becomes event number 1.
   assign l1a_acc = L1A && !L1ASRST;
   assign cnt_new = L1ARST ? CNT_ONE : L1ACNT + CNT_ONE;

   always_ff @(posedge CLKCMS or negedge RSTN) begin
      if (!RSTN) begin
         L1ACNT <= '0;
      end else if (L1ASRST) begin
         L1ACNT <= '0;
      end else if (l1a_acc) begin
         L1ACNT <= cnt_new;
      end else if (L1ARST) begin
         L1ACNT <= '0;
      end
   end

   always_ff @(posedge CLKCMS or negedge RSTN) begin
      if (!RSTN) begin
         L1A_VALID <= 1'b0;
         L1A_BXN   <= '0;
         L1A_NUM   <= '0;
      end else begin
         L1A_VALID <= l1a_acc;
         if (l1a_acc) begin
            L1A_BXN <= BXN;
            L1A_NUM <= cnt_new;
         end
      end
   end

`ifdef BXL1A_ERRCNT_EN
   logic       errcnt_inc;
   logic [7:0] errcnt;

   // Mismatches count in both SYNCED and ERROR; only RSTN clears the counter.
   assign errcnt_inc = bc0_mismatch && (state != ST_UNSYNC);

   always_ff @(posedge CLKCMS or negedge RSTN) begin
      if (!RSTN) begin
         errcnt <= 8'h00;
      end else if (errcnt_inc && (errcnt != 8'hFF)) begin
         errcnt <= errcnt + 8'd1;
      end
   end

   assign BC0_ERRCNT = errcnt;
`else
   assign BC0_ERRCNT = 8'h00;
`endif

endmodule

// File: tb/tb_bxl1a_cntr.sv
// Self-checking bench for bxl1a_cntr: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of counters, sync flag and tags.
module tb_bxl1a_cntr;

   localparam int BXMAX = 3563;
   localparam int BXOFF = 0;
   localparam int L1AW  = 24;
`ifdef BXL1A_ERRCNT_EN
   localparam bit ERRCNT_EN = 1'b1;
`else
   localparam bit ERRCNT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic clkena = 1'b0, bc0 = 1'b0, bxrst = 1'b0;
   logic l1arst = 1'b0, l1asrst = 1'b0, l1a = 1'b0;

   logic [11:0]     bxn, l1a_bxn;
   logic [L1AW-1:0] l1acnt, l1a_num;
   logic            l1a_valid, synced, bc0_err;
   logic [7:0]      bc0_errcnt;
   logic [1:0]      fsm_state;

   bxl1a_cntr #(
      .BX_MAX    (BXMAX),
      .BX_OFFSET (BXOFF),
      .L1A_WIDTH (L1AW)
   ) dut (
      .CLKCMS     (clk),
      .RSTN       (rstn),
      .CLKENA     (clkena),
      .BC0        (bc0),
      .BXRST      (bxrst),
      .L1ARST     (l1arst),
      .L1ASRST    (l1asrst),
      .L1A        (l1a),
      .BXN        (bxn),
      .L1ACNT     (l1acnt),
      .L1A_VALID  (l1a_valid),
      .L1A_BXN    (l1a_bxn),
      .L1A_NUM    (l1a_num),
      .SYNCED     (synced),
      .BC0_ERR    (bc0_err),
      .BC0_ERRCNT (bc0_errcnt),
      .fsm_state  (fsm_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   bit check_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model: plain integers and flags
   int              m_bxn, m_errcnt, m_tag_bxn, mt_nat, mt_old;
   bit              m_synced, m_err, m_valid;
   logic [L1AW-1:0] m_cnt, m_tag_num;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_bxn = 0; m_errcnt = 0; m_tag_bxn = 0;
         m_synced = 0; m_err = 0; m_valid = 0;
         m_cnt = '0; m_tag_num = '0;
      end else begin
         mt_old = m_bxn;
         if (clkena) mt_nat = (m_bxn == BXMAX) ? BXOFF : m_bxn + 1;
         else        mt_nat = m_bxn;
         if (bxrst) begin
            m_synced = 1; m_err = 0;
         end else if (bc0) begin
            if (m_synced && mt_nat != BXOFF) begin
               m_err = 1;
               if (m_errcnt < 255) m_errcnt++;
            end
            m_synced = 1;
         end
         m_bxn = (bxrst || bc0) ? BXOFF : mt_nat;
         m_valid = 0;
         if (l1asrst) begin
            m_cnt = '0;
         end else if (l1a) begin
            m_cnt = l1arst ? 1 : m_cnt + 1;
            m_valid = 1; m_tag_bxn = mt_old; m_tag_num = m_cnt;
         end else if (l1arst) begin
            m_cnt = '0;
         end
      end
   end

   // compare process
   always @(negedge clk) begin
      if (check_en) begin
         chk("bxn", 32'(bxn), 32'(m_bxn));
         chk("l1acnt", 32'(l1acnt), 32'(m_cnt));
         chk("l1a_valid", 32'(l1a_valid), 32'(m_valid));
         chk("l1a_bxn", 32'(l1a_bxn), 32'(m_tag_bxn));
         chk("l1a_num", 32'(l1a_num), 32'(m_tag_num));
         chk("synced", 32'(synced), 32'(m_synced));
         chk("bc0_err", 32'(bc0_err), 32'(m_err));
         chk("bc0_errcnt", 32'(bc0_errcnt), ERRCNT_EN ? 32'(m_errcnt) : 32'd0);
         chk("fsm_state", 32'(fsm_state), !m_synced ? 32'd0 : (m_err ? 32'd2 : 32'd1));
      end
   end

   // driver
   task automatic tick(input bit ce, input bit b0, input bit br,
                       input bit lr, input bit ls, input bit la);
      clkena = ce; bc0 = b0; bxrst = br; l1arst = lr; l1asrst = ls; l1a = la;
      @(negedge clk);
   endtask

   int srst_left = 0;

   initial begin
      bit ce, b0, ls;
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_bxn", 32'(bxn), 0);
      chk("rst_l1acnt", 32'(l1acnt), 0);
      chk("rst_synced", 32'(synced), 0);
      chk("rst_bc0_err", 32'(bc0_err), 0);
      chk("rst_valid", 32'(l1a_valid), 0);
      chk("rst_errcnt", 32'(bc0_errcnt), 0);
      rstn = 1'b1;
      check_en = 1'b1;

      // full orbit after BXRST, aligned BC0 on the wrap cycle
      tick(1, 0, 1, 0, 0, 0);
      chk("bxrst_bxn", 32'(bxn), 0);
      chk("bxrst_synced", 32'(synced), 1);
      for (int i = 1; i <= BXMAX; i++) begin
         tick(1, 0, 0, 0, 0, 0);
         chk("orbit_seq", 32'(bxn), 32'(i));
      end
      tick(1, 1, 0, 0, 0, 0);
      chk("wrap_bxn", 32'(bxn), 0);
      chk("wrap_bc0_err", 32'(bc0_err), 0);
      chk("wrap_synced", 32'(synced), 1);

      // misaligned BC0 at BX 100
      repeat (100) tick(1, 0, 0, 0, 0, 0);
      chk("pre_bc0_bxn", 32'(bxn), 100);
      tick(1, 1, 0, 0, 0, 0);
      chk("mis_bxn", 32'(bxn), 0);
      chk("mis_bc0_err", 32'(bc0_err), 1);
      chk("mis_state", 32'(fsm_state), 2);
      chk("mis_errcnt", 32'(bc0_errcnt), ERRCNT_EN ? 32'd1 : 32'd0);
      tick(1, 0, 1, 0, 0, 0);
      chk("clr_bc0_err", 32'(bc0_err), 0);
      chk("clr_state", 32'(fsm_state), 1);

      // back-to-back L1As at BX 37 and 38
      repeat (37) tick(1, 0, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0, 1);
      chk("tag1_valid", 32'(l1a_valid), 1);
      chk("tag1_bxn", 32'(l1a_bxn), 37);
      chk("tag1_num", 32'(l1a_num), 1);
      tick(1, 0, 0, 0, 0, 1);
      chk("tag2_valid", 32'(l1a_valid), 1);
      chk("tag2_bxn", 32'(l1a_bxn), 38);
      chk("tag2_num", 32'(l1a_num), 2);
      tick(1, 0, 0, 0, 0, 0);
      chk("tag_idle_valid", 32'(l1a_valid), 0);
      chk("tag_hold_num", 32'(l1a_num), 2);

      // L1ARST together with L1A at count 5
      repeat (3) begin
         tick(1, 0, 0, 0, 0, 1);
         tick(1, 0, 0, 0, 0, 0);
      end
      chk("cnt5", 32'(l1acnt), 5);
      tick(1, 0, 0, 1, 0, 1);
      chk("l1arst_cnt", 32'(l1acnt), 1);
      chk("l1arst_num", 32'(l1a_num), 1);
      chk("l1arst_valid", 32'(l1a_valid), 1);

      // 16-cycle soft reset window with 3 L1As inside
      for (int i = 0; i < 16; i++) begin
         tick(1, 0, 0, 0, 1, (i == 2 || i == 7 || i == 12));
         chk("srst_valid", 32'(l1a_valid), 0);
         chk("srst_cnt", 32'(l1acnt), 0);
      end
      tick(1, 0, 0, 0, 0, 1);
      chk("post_srst_num", 32'(l1a_num), 1);
      chk("post_srst_valid", 32'(l1a_valid), 1);

      // CLKENA low at BX 200, BC0 inside the window
      tick(1, 0, 1, 0, 0, 0);
      repeat (200) tick(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         tick(0, (i == 4), 0, 0, 0, 0);
         chk("hold_bxn", 32'(bxn), (i < 4) ? 32'd200 : 32'd0);
      end
      chk("hold_bc0_err", 32'(bc0_err), 1);
      tick(1, 0, 1, 0, 0, 0);

      // randomized traffic
      for (int n = 0; n < 6000; n++) begin
         ce = ($urandom_range(0, 9) != 0);
         if (m_bxn == BXMAX && ce) b0 = $urandom_range(0, 1) == 1;
         else                      b0 = ($urandom_range(0, 499) == 0);
         if (srst_left > 0) begin
            ls = 1; srst_left--;
         end else if ($urandom_range(0, 199) == 0) begin
            ls = 1; srst_left = $urandom_range(0, 15);
         end else begin
            ls = 0;
         end
         tick(ce, b0, ($urandom_range(0, 999) == 0), ($urandom_range(0, 149) == 0),
              ls, ($urandom_range(0, 3) == 0));
      end

      // asynchronous reset mid-cycle
      tick(1, 0, 0, 0, 0, 1);
      @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("async_bxn", 32'(bxn), 0);
      chk("async_cnt", 32'(l1acnt), 0);
      chk("async_valid", 32'(l1a_valid), 0);
      chk("async_synced", 32'(synced), 0);
      chk("async_num", 32'(l1a_num), 0);
      @(negedge clk);
      rstn = 1'b1;
      tick(1, 0, 0, 0, 0, 1);
      chk("after_rst_num", 32'(l1a_num), 1);
      tick(0, 0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bxl1a_cntr.md
Name: bxl1a_cntr

Overview:
- Bunch-crossing and L1A event counter stage directly downstream of the CCB command decoder.
- Consumes the decoded CLKENA, BC0, BXRST, L1ARST and L1ASRST, plus the L1A strobe.
- Maintains the orbit-aligned BX number and the L1A event number, checks BC0 alignment, and tags each accepted L1A with {BX, event number} for the DAQ header logic.

Parameters:
- BX_MAX, 3563: last BX index in an orbit; counter wraps BX_MAX -> BX_OFFSET.
- BX_OFFSET, 0: value loaded into the BX counter on BC0/BXRST. Must be <= BX_MAX.
- L1A_WIDTH, 24: width of the L1A event counter.

Ports:
- CLKCMS  in  1  40 MHz LHC clock; all logic on rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- CLKENA  in  1  BX counting enable (decoded, active high).
- BC0  in  1  one-cycle bunch-crossing-zero strobe.
- BXRST  in  1  one-cycle BX counter reset.
- L1ARST  in  1  one-cycle L1A counter reset.
- L1ASRST  in  1  L1A soft reset, level, up to 16 cycles.
- L1A  in  1  one-cycle level-1 accept strobe.
- BXN  out  12  current BX number.
- L1ACNT  out  L1A_WIDTH  number of accepted L1As.
- L1A_VALID  out  1  one-cycle tag-valid pulse.
- L1A_BXN  out  12  BX number captured at the accepted L1A.
- L1A_NUM  out  L1A_WIDTH  event number of the accepted L1A.
- SYNCED  out  1  BX counter aligned to BC0.
- BC0_ERR  out  1  sticky BC0 misalignment flag.
- BC0_ERRCNT  out  8  BC0 mismatch count (see Optional Feature).

Behaviour:
- Reset (RSTN=0, asynchronous): all outputs 0, FSM=UNSYNC.
- BX counter:
  - Priority: BXRST > BC0 > count.
  - BXRST or BC0 -> BXN <= BX_OFFSET next cycle, regardless of CLKENA.
  - Otherwise, if CLKENA=1: BXN <= (BXN==BX_MAX) ? BX_OFFSET : BXN+1.
  - CLKENA=0 -> BXN holds.
- Sync FSM (3 states; SYNCED=1 in SYNCED and ERROR):
  - UNSYNC: BC0 or BXRST -> SYNCED.
  - SYNCED: on BC0 without BXRST, compute the natural next value (wrapped increment if CLKENA, else hold). If it differs from BX_OFFSET: BC0_ERR<=1, go to ERROR. The counter is still reloaded with BX_OFFSET. BXRST alone stays in SYNCED, no check.
  - ERROR: BXRST -> SYNCED and clear BC0_ERR. BC0 still reloads BXN; BC0_ERR stays set.
  - BXRST together with BC0 in any state: treated as BXRST only; no alignment check.
- L1A counter:
  - Accepted L1A = L1A && !L1ASRST.
  - L1ARST -> L1ACNT <= 0. If an accepted L1A arrives in the same cycle, L1ACNT <= 1 and that event is numbered 1.
  - While L1ASRST=1: L1ACNT forced to 0 and L1A is ignored (no count, no tag).
  - Accepted L1A otherwise -> L1ACNT <= L1ACNT+1, wrapping modulo 2^L1A_WIDTH. The first event after reset is number 1.
- Tagging: latency 1 cycle. In the cycle after an accepted L1A: L1A_VALID=1, L1A_BXN = BXN as sampled in the L1A cycle, L1A_NUM = new L1ACNT. L1A_BXN/L1A_NUM hold until the next tag. Back-to-back L1As produce back-to-back tags.
- L1A is counted in every FSM state, including UNSYNC; tags carry the raw BXN.

Optional Feature:
- Macro BXL1A_ERRCNT_EN.
- Defined: BC0_ERRCNT increments on every BC0 mismatch detected in SYNCED or ERROR (mismatch in ERROR also counts), saturating at 8'hFF. Cleared by RSTN only.
- Undefined: BC0_ERRCNT tied to 8'h00 and no counter logic is synthesized.

Decomposition:
- Shared package (ccb_pkg) holds:
  - FSM state encoding: UNSYNC=2'd0, SYNCED=2'd1, ERROR=2'd2.
  - Constants LHC_BX_MAX=3563 and BXN_W=12.
- One sub-module, bx_orbit_cntr: BX counter plus wrap/next-value logic, exporting BXN and the natural next value for the alignment check. The FSM, L1A counter and tagging stay in the top.

Test Plan:
- RSTN pulse, then BXRST, then 3564 cycles with CLKENA=1 and BC0 on the wrap cycle -> BXN sequence 0..3563,0; SYNCED=1; BC0_ERR=0.
- Synced; BC0 injected at BXN=100 -> BXN=0 next cycle, BC0_ERR=1, state ERROR; with macro, BC0_ERRCNT=1. BXRST then clears BC0_ERR.
- L1A at BXN=37, then L1A again next cycle -> L1A_VALID for 2 cycles with (L1A_BXN=37, L1A_NUM=1) then (38, 2).
- L1ACNT=5, L1ARST together with L1A -> L1ACNT=1, tag L1A_NUM=1.
- L1ASRST held 16 cycles with 3 L1As inside the window -> no tags, L1ACNT=0. First L1A after the window -> L1A_NUM=1.
- CLKENA=0 for 10 cycles at BXN=200 -> BXN holds at 200; a BC0 during that window with BX_OFFSET=0 sets BC0_ERR.
